// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative HI/LO multiply/divide unit.
// One bit per cycle, 32 CALC cycles. Multiply uses radix-2 shift-add and
// divide uses restoring division, both on operand magnitudes. The sign fix
// and the divide-by-zero override are applied on the last CALC edge, so the
// result is already in the result registers during DONE.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        wen_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Magnitude of an operand. 0x80000000 maps to 2^31, which fits in 32 bits.
  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_mag_b;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_div;
  logic        w_signed;
  logic        w_sign_diff;
  logic        w_b_zero;
  logic [32:0] w_sum;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;
  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_ge;
  logic [31:0] w_div_hi;
  logic [31:0] w_div_lo;
  logic [63:0] w_prod;
  logic [31:0] w_fin_hi;
  logic [31:0] w_fin_lo;
  logic        w_in_done;

  assign w_is_div    = r_op[1];
  assign w_signed    = ~r_op[0];
  assign w_sign_diff = r_a[31] ^ r_b[31];
  assign w_b_zero    = (r_b == 32'd0);

  // Shift-add step: conditionally add multiplicand into HI, then shift {carry,HI,LO} right.
  assign w_sum    = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_b} : 33'd0);
  assign w_mul_hi = w_sum[32:1];
  assign w_mul_lo = {w_sum[0], r_acc_lo[31:1]};

  // Restoring step: shift next dividend bit into the partial remainder and trial-subtract.
  assign w_trial  = {r_acc_hi, r_acc_lo[31]};
  assign w_diff   = w_trial - {1'b0, r_mag_b};
  assign w_ge     = (w_trial >= {1'b0, r_mag_b});
  assign w_div_hi = w_ge ? w_diff[31:0] : w_trial[31:0];
  assign w_div_lo = {r_acc_lo[30:0], w_ge};

  assign w_prod   = {w_mul_hi, w_mul_lo};

  // Final result of the last iteration with sign fix and divide-by-zero override.
  always_comb begin
    w_fin_hi = w_div_hi;
    w_fin_lo = w_div_lo;
    if (!w_is_div) begin
      if (w_signed && w_sign_diff) begin
        {w_fin_hi, w_fin_lo} = 64'd0 - w_prod;
      end else begin
        {w_fin_hi, w_fin_lo} = w_prod;
      end
    end else if (w_b_zero) begin
      w_fin_hi = r_a;
      w_fin_lo = 32'hFFFF_FFFF;
    end else begin
      w_fin_lo = (w_signed && w_sign_diff) ? (32'd0 - w_div_lo) : w_div_lo;
      w_fin_hi = (w_signed && r_a[31])     ? (32'd0 - w_div_hi) : w_div_hi;
    end
  end

  // Control FSM, datapath registers and committed HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_mag_b  <= 32'd0;
      r_acc_hi <= 32'd0;
      r_acc_lo <= 32'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i && !flush_i) begin
            r_op     <= op_i;
            r_a      <= a_i;
            r_b      <= b_i;
            r_mag_b  <= f_mag(b_i, ~op_i[0]);
            r_acc_hi <= 32'd0;
            r_acc_lo <= f_mag(a_i, ~op_i[0]);
            r_cnt    <= 6'd0;
            r_state  <= ST_CALC;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (flush_i) begin
            r_state <= ST_IDLE;
          end else begin
            r_acc_hi <= w_is_div ? w_div_hi : w_mul_hi;
            r_acc_lo <= w_is_div ? w_div_lo : w_mul_lo;
            r_cnt    <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) begin
              r_res_hi <= w_fin_hi;
              r_res_lo <= w_fin_lo;
              r_state  <= ST_DONE;
            end else begin
              r_state  <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          // A flush here abandons the result; HI/LO keep the previous one.
          if (!flush_i) begin
            r_hi <= r_res_hi;
            r_lo <= r_res_lo;
          end else begin
            r_hi <= r_hi;
            r_lo <= r_lo;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_in_done = (r_state == ST_DONE);
  assign busy_o    = (r_state == ST_CALC) || ((r_state == ST_IDLE) && start_i);
  assign done_o    = w_in_done && !flush_i;
  assign wen_o     = w_in_done && !flush_i;
  assign hi_o      = done_o ? r_res_hi : r_hi;
  assign lo_o      = done_o ? r_res_lo : r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: expected {hi,lo} pushed to a
// scoreboard queue at start, popped and compared when done_o is seen.
module tb_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic        wen_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  muldiv_ctrl dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
    .done_o(done_o), .wen_o(wen_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: {hi, lo} for each operation.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done_o (bounded); check latency, busy, result and pulse width.
  task automatic wait_done(input string tag, input bit drop);
    int k = 0;
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    logic [63:0] e;
    while (k < 60 && !seen) begin
      tick();
      k++;
      if (k == 1 && drop) begin
        start_i = 1'b0;
        op_i = 2'($urandom);
        a_i = $urandom;
        b_i = $urandom;
      end
      if (done_o) seen = 1'b1;
      else if (!busy_o) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, 64'(k), 64'd33);
    chk({tag, "_busy_calc"}, {63'd0, busy_ok}, 64'd1);
    if (seen) begin
      chk({tag, "_wen"}, {63'd0, wen_o}, 64'd1);
      chk({tag, "_busy_done"}, {63'd0, busy_o}, 64'd0);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, e[63:32]});
        chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, e[31:0]});
        last_hi = e[63:32];
        last_lo = e[31:0];
      end else begin
        chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end
      tick();
      chk({tag, "_pulse"}, {62'd0, done_o, wen_o}, 64'd0);
      chk({tag, "_hold_hi"}, {32'd0, hi_o}, {32'd0, last_hi});
      chk({tag, "_hold_lo"}, {32'd0, lo_o}, {32'd0, last_lo});
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    #1;
    chk({tag, "_busy0"}, {63'd0, busy_o}, 64'd1);
    exp_q.push_back(model(op, a, b));
    wait_done(tag, 1'b1);
  endtask

  initial begin
    bit bad;
    resetn = 1'b1; start_i = 1'b0; op_i = 2'd0; a_i = 32'd0; b_i = 32'd0; flush_i = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_outs", {busy_o, done_o, wen_o, hi_o, lo_o}, 64'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    chk("idle_busy", {63'd0, busy_o}, 64'd0);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max_const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5);
    chk("mult_neg_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0);
    chk("divu_zero_const", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FFF7, 32'd0);
    run_op("div_negdiv", 2'b10, 32'd7, 32'hFFFF_FFFE);
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("rnd%0d", i), 2'(i % 4), $urandom, (i == 3) ? 32'($urandom_range(1, 300)) : $urandom);
    end

    // Flush during CALC: no result, HI/LO unchanged.
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd7;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done_o || wen_o || busy_o) bad = 1'b1;
      tick();
    end
    chk("flush_no_done", {63'd0, bad}, 64'd0);
    chk("flush_hold", {hi_o, lo_o}, {last_hi, last_lo});
    run_op("after_flush", 2'b01, 32'd2, 32'd3);
    chk("after_flush_lo", {32'd0, lo_o}, 64'd6);

    // Reset mid-CALC of a DIV.
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd1000; b_i = 32'd3;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    resetn = 1'b0;
    #1;
    chk("midrst_outs", {busy_o, done_o, wen_o, hi_o, lo_o}, 64'd0);
    tick();
    resetn = 1'b1;
    last_hi = 32'd0; last_lo = 32'd0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (wen_o || done_o) bad = 1'b1;
    end
    chk("midrst_no_wen", {63'd0, bad}, 64'd0);

    // start_i held through DONE: next op accepted one cycle after DONE.
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd9; b_i = 32'd11;
    #1;
    exp_q.push_back(model(2'b01, 32'd9, 32'd11));
    wait_done("held_a", 1'b0);
    chk("held_idle_busy", {63'd0, busy_o}, 64'd1);
    op_i = 2'b11; a_i = 32'd1000; b_i = 32'd7;
    exp_q.push_back(model(2'b11, 32'd1000, 32'd7));
    wait_done("held_b", 1'b1);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have a single clock `clk`, rising-edge.
REQ-002 The block SHALL have an asynchronous, active-low reset `resetn`.
REQ-003 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start_i  in  1  request a new HI/LO operation
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a_i  in  32  rs operand
- b_i  in  32  rt operand
- flush_i  in  1  abort the in-flight operation (exception/pipeline flush)
- busy_o  out  1  stall request to hazard unit
- done_o  out  1  one-cycle result-valid pulse
- wen_o  out  1  HI and LO write enable, same cycle as done_o
- hi_o  out  32  HI result
- lo_o  out  32  LO result

Function
REQ-004 States SHALL be IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-005 IDLE with start_i=1 and flush_i=0 SHALL latch op_i, a_i and b_i, clear the 6-bit iteration counter and move to CALC.
REQ-006 Signed ops (MULT, DIV) SHALL compute on operand magnitudes; 0x80000000 SHALL be treated as magnitude 2^31 with no overflow.
REQ-007 Multiplication SHALL be a radix-2 shift-add producing a 64-bit product {hi,lo}, one bit per CALC cycle.
REQ-008 Division SHALL be restoring, one quotient bit per CALC cycle, producing quotient in lo and remainder in hi.
REQ-009 CALC SHALL last exactly 32 cycles (counter 0..31); on counter==31 the state SHALL move to DONE.
REQ-010 Sign fix in DONE:
- MULT product negated (64-bit two's complement) when operand signs differ.
- DIV quotient negated when signs differ.
- DIV remainder takes the sign of a_i.
REQ-011 If the latched b is 0 for DIV or DIVU, the result SHALL be lo=0xFFFFFFFF and hi=latched a, with no trap.
REQ-012 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000.
REQ-013 In DONE, done_o and wen_o SHALL be 1 for exactly one cycle, hi_o/lo_o SHALL carry the final result, and the next state SHALL be IDLE.
REQ-014 hi_o and lo_o SHALL be registered and SHALL hold the last completed result until the next DONE.
REQ-015 busy_o SHALL be 1 in CALC, and in IDLE when start_i=1; it SHALL be 0 in DONE and otherwise 0.
REQ-016 Latency SHALL be: start sampled at edge 0, done_o high in the cycle after edge 32 (33 cycles total).
REQ-017 start_i in CALC or DONE SHALL be ignored; the requester SHALL hold start_i, and it is accepted in the next IDLE cycle.
REQ-018 flush_i=1 in CALC or DONE SHALL force IDLE on the next edge, suppress done_o/wen_o, and leave hi_o/lo_o unchanged.
REQ-019 flush_i=1 together with start_i=1 in IDLE SHALL not start an operation.

Reset
REQ-020 On resetn=0 the block SHALL asynchronously enter IDLE, clear the counter and operand registers, and drive busy_o=0, done_o=0, wen_o=0, hi_o=0, lo_o=0.
REQ-021 Reset asserted mid-CALC SHALL discard the operation with no wen_o pulse after release.

Verification
REQ-022 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at cycle 33, done_o=wen_o=1, hi=0xFFFFFFFE, lo=0x00000001; busy_o=1 for cycles 0-32.
REQ-023 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-024 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007.
REQ-025 DIVU 100/7, flush_i pulsed at cycle 10 -> no done_o/wen_o, busy_o=0 from cycle 11, hi_o/lo_o keep prior values; a new MULTU 2*3 then completes with lo=6 after 33 cycles.
REQ-026 resetn low at cycle 15 of a DIV -> all outputs 0 immediately, no wen_o after release; start_i held through DONE of a prior op -> accepted exactly one cycle after DONE.
